// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall controller beside the ID stage of the in-order pipeline.
// Defining HAZ_PERF_EN adds saturating load-stall, long-stall and flush event counters.
module pipe_hazard_ctrl #(
   parameter int RAW      = 5,
   parameter int STAGES   = 3,
   parameter int LOAD_LAT = 1,
   parameter int LATW     = 6,
   localparam int FW      = $clog2(STAGES)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [RAW-1:0]  id_rs1,
   input  logic [RAW-1:0]  id_rs2,
   input  logic [RAW-1:0]  id_rd,
   input  logic            id_wen,
   input  logic [1:0]      id_kind,
   input  logic [LATW-1:0] id_lat,
   input  logic            branch_taken,
   output logic            stall,
   output logic            bubble,
   output logic            if_flush,
   output logic [FW-1:0]   fwd_a,
   output logic [FW-1:0]   fwd_b,
   output logic            lu_start,
   output logic            lu_busy,
   output logic            lu_wb_valid,
`ifdef HAZ_PERF_EN
   output logic [31:0]     perf_load_stalls,
   output logic [31:0]     perf_long_stalls,
   output logic [31:0]     perf_flushes,
`endif
   output logic [RAW-1:0]  lu_wb_rd
);

   localparam logic [1:0] KIND_LOAD = 2'b01;
   localparam logic [1:0] KIND_LONG = 2'b10;

   typedef enum logic [1:0] {LU_IDLE, LU_BUSY, LU_DONE} lu_state_t;

   logic            tag_v   [STAGES];
   logic [RAW-1:0]  tag_rd  [STAGES];
   logic            tag_wen [STAGES];
   logic            tag_ld  [STAGES];
   logic [RAW-1:0]  ex_rs1;
   logic [RAW-1:0]  ex_rs2;
   lu_state_t       lu_state;
   logic [LATW-1:0] lu_count;
   logic [RAW-1:0]  lu_rd;
   logic            load_stall;
   logic            long_stall;
   logic            issue;

   // A load younger than LOAD_LAT stages cannot feed the instruction in ID yet
   always_comb begin
      load_stall = 1'b0;
      for (int k = 0; k < LOAD_LAT; k++) begin
         if (tag_v[k] && tag_wen[k] && tag_ld[k] && tag_rd[k] != '0 &&
             (tag_rd[k] == id_rs1 || tag_rd[k] == id_rs2))
            load_stall = 1'b1;
      end
      load_stall = load_stall & id_valid;
   end

   always_comb begin
      long_stall = 1'b0;
      if (id_valid && lu_state != LU_IDLE) begin
         if (id_kind == KIND_LONG)
            long_stall = 1'b1;
         if (lu_rd != '0 && (id_rs1 == lu_rd || id_rs2 == lu_rd))
            long_stall = 1'b1;
         if (id_wen && id_rd == lu_rd)
            long_stall = 1'b1;
      end
   end

   assign stall    = load_stall | long_stall;
   assign bubble   = stall;
   assign issue    = id_valid & ~stall;
   assign if_flush = id_valid & branch_taken & ~stall;

   // Long ops enter the tag pipe without a write; the long unit owns that writeback
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < STAGES; k++) begin
            tag_v[k]   <= 1'b0;
            tag_rd[k]  <= '0;
            tag_wen[k] <= 1'b0;
            tag_ld[k]  <= 1'b0;
         end
         ex_rs1 <= '0;
         ex_rs2 <= '0;
      end else begin
         tag_v[0]   <= issue;
         tag_rd[0]  <= issue ? id_rd : '0;
         tag_wen[0] <= issue & id_wen & (id_kind != KIND_LONG);
         tag_ld[0]  <= issue & (id_kind == KIND_LOAD);
         ex_rs1     <= issue ? id_rs1 : '0;
         ex_rs2     <= issue ? id_rs2 : '0;
         for (int k = 1; k < STAGES; k++) begin
            tag_v[k]   <= tag_v[k-1];
            tag_rd[k]  <= tag_rd[k-1];
            tag_wen[k] <= tag_wen[k-1];
            tag_ld[k]  <= tag_ld[k-1];
         end
      end
   end

   // Walk oldest to youngest so the youngest producer overrides
   always_comb begin
      fwd_a = '0;
      fwd_b = '0;
      for (int k = STAGES - 1; k >= 1; k--) begin
         if (tag_v[k] && tag_wen[k] && tag_rd[k] != '0) begin
            if (tag_rd[k] == ex_rs1)
               fwd_a = FW'(k);
            if (tag_rd[k] == ex_rs2)
               fwd_b = FW'(k);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lu_state <= LU_IDLE;
         lu_count <= '0;
         lu_rd    <= '0;
         lu_start <= 1'b0;
      end else begin
         lu_start <= 1'b0;
         case (lu_state)
            LU_IDLE: begin
               if (issue && id_kind == KIND_LONG) begin
                  lu_state <= LU_BUSY;
                  lu_start <= 1'b1;
                  lu_rd    <= id_rd;
                  lu_count <= (id_lat == '0) ? LATW'(1) : id_lat;
               end
            end
            LU_BUSY: begin
               if (lu_count == LATW'(1))
                  lu_state <= LU_DONE;
               lu_count <= lu_count - LATW'(1);
            end
            LU_DONE: lu_state <= LU_IDLE;
            default: lu_state <= LU_IDLE;
         endcase
      end
   end

   assign lu_busy     = (lu_state != LU_IDLE);
   assign lu_wb_valid = (lu_state == LU_DONE);
   assign lu_wb_rd    = lu_wb_valid ? lu_rd : '0;

`ifdef HAZ_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_load_stalls <= '0;
         perf_long_stalls <= '0;
         perf_flushes     <= '0;
      end else begin
         if (load_stall && perf_load_stalls != '1)
            perf_load_stalls <= perf_load_stalls + 32'd1;
         if (long_stall && perf_long_stalls != '1)
            perf_long_stalls <= perf_long_stalls + 32'd1;
         if (if_flush && perf_flushes != '1)
            perf_flushes <= perf_flushes + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Drives a 3-stage/1-load-cycle and a 4-stage/2-load-cycle controller from shared ID inputs;
// expectations come from a cycle-indexed issue log and arithmetic long-unit timing.
module tb_pipe_hazard_ctrl;

   localparam int NCFG = 2;
   localparam int LOGN = 4096;

   typedef struct packed {
      logic       v;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       wen;
      logic       ld;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       id_valid = 1'b0;
   logic [4:0] id_rs1 = '0;
   logic [4:0] id_rs2 = '0;
   logic [4:0] id_rd = '0;
   logic       id_wen = 1'b0;
   logic [1:0] id_kind = '0;
   logic [5:0] id_lat = '0;
   logic       branch_taken = 1'b0;

   logic       stall_o    [NCFG];
   logic       bubble_o   [NCFG];
   logic       flush_o    [NCFG];
   logic [1:0] fwd_a_o    [NCFG];
   logic [1:0] fwd_b_o    [NCFG];
   logic       lu_start_o [NCFG];
   logic       lu_busy_o  [NCFG];
   logic       lu_wbv_o   [NCFG];
   logic [4:0] lu_wbrd_o  [NCFG];
`ifdef HAZ_PERF_EN
   logic [31:0] perf_ld [NCFG];
   logic [31:0] perf_lg [NCFG];
   logic [31:0] perf_fl [NCFG];
`endif

   ent_t       issued_log [NCFG][LOGN];
   int         cyc;
   logic       lu_active [NCFG];
   int         lu_first  [NCFG];
   int         lu_len    [NCFG];
   logic [4:0] lu_dst    [NCFG];
   int         checks = 0;
   int         passed = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.STAGES(3), .LOAD_LAT(1)) u_cfg0 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_wen(id_wen), .id_kind(id_kind), .id_lat(id_lat),
      .branch_taken(branch_taken), .stall(stall_o[0]), .bubble(bubble_o[0]),
      .if_flush(flush_o[0]), .fwd_a(fwd_a_o[0]), .fwd_b(fwd_b_o[0]),
      .lu_start(lu_start_o[0]), .lu_busy(lu_busy_o[0]), .lu_wb_valid(lu_wbv_o[0]),
`ifdef HAZ_PERF_EN
      .perf_load_stalls(perf_ld[0]), .perf_long_stalls(perf_lg[0]), .perf_flushes(perf_fl[0]),
`endif
      .lu_wb_rd(lu_wbrd_o[0])
   );

   pipe_hazard_ctrl #(.STAGES(4), .LOAD_LAT(2)) u_cfg1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_wen(id_wen), .id_kind(id_kind), .id_lat(id_lat),
      .branch_taken(branch_taken), .stall(stall_o[1]), .bubble(bubble_o[1]),
      .if_flush(flush_o[1]), .fwd_a(fwd_a_o[1]), .fwd_b(fwd_b_o[1]),
      .lu_start(lu_start_o[1]), .lu_busy(lu_busy_o[1]), .lu_wb_valid(lu_wbv_o[1]),
`ifdef HAZ_PERF_EN
      .perf_load_stalls(perf_ld[1]), .perf_long_stalls(perf_lg[1]), .perf_flushes(perf_fl[1]),
`endif
      .lu_wb_rd(lu_wbrd_o[1])
   );

   function automatic int cfgStages(input int i);
      return (i == 0) ? 3 : 4;
   endfunction

   function automatic int cfgLoadLat(input int i);
      return (i == 0) ? 1 : 2;
   endfunction

   // Instruction sitting k stages past ID now is the one issued k cycles before this one
   function automatic ent_t inStage(input int i, input int k);
      ent_t e;
      e = '0;
      if (cyc - k >= 1)
         e = issued_log[i][(cyc - k) % LOGN];
      return e;
   endfunction

   function automatic logic writes(input ent_t e, input logic [4:0] r);
      return e.v && e.wen && e.rd == r && r != 5'd0;
   endfunction

   function automatic logic luBusy(input int i);
      return lu_active[i] && cyc >= lu_first[i] && cyc <= lu_first[i] + lu_len[i];
   endfunction

   function automatic logic expLoadStall(input int i);
      ent_t e;
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < cfgLoadLat(i); k++) begin
         e = inStage(i, k);
         if (e.ld && (writes(e, id_rs1) || writes(e, id_rs2)))
            hit = 1'b1;
      end
      return id_valid && hit;
   endfunction

   function automatic logic expLongStall(input int i);
      if (!id_valid || !luBusy(i))
         return 1'b0;
      return id_kind == 2'b10 ||
             (lu_dst[i] != 5'd0 && (id_rs1 == lu_dst[i] || id_rs2 == lu_dst[i])) ||
             (id_wen && id_rd == lu_dst[i]);
   endfunction

   function automatic logic [1:0] expFwd(input int i, input logic [4:0] r);
      logic [1:0] sel;
      logic       found;
      sel = 2'd0;
      found = 1'b0;
      for (int k = 1; k < cfgStages(i); k++) begin
         if (!found && writes(inStage(i, k), r)) begin
            sel = 2'(k);
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   task automatic checkOne(input string tag, input int inst, input logic [31:0] obs,
                           input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("[TB] FAIL %s cfg%0d cyc%0d observed=%0d expected=%0d", tag, inst, cyc, obs, exp);
   endtask

   task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic wen, input logic [1:0] kind,
                                input logic [5:0] lat, input logic br);
      id_valid     = v;
      id_rs1       = rs1;
      id_rs2       = rs2;
      id_rd        = rd;
      id_wen       = wen;
      id_kind      = kind;
      id_lat       = lat;
      branch_taken = br;
      #1;
   endtask

   task automatic checkOutput();
      ent_t ex;
      logic st;
      logic wbv;
      for (int i = 0; i < NCFG; i++) begin
         ex  = inStage(i, 0);
         st  = expLoadStall(i) || expLongStall(i);
         wbv = lu_active[i] && cyc == lu_first[i] + lu_len[i];
         checkOne("stall", i, stall_o[i], st);
         checkOne("bubble", i, bubble_o[i], st);
         checkOne("if_flush", i, flush_o[i], id_valid && branch_taken && !st);
         checkOne("fwd_a", i, fwd_a_o[i], expFwd(i, ex.rs1));
         checkOne("fwd_b", i, fwd_b_o[i], expFwd(i, ex.rs2));
         checkOne("lu_start", i, lu_start_o[i], lu_active[i] && cyc == lu_first[i]);
         checkOne("lu_busy", i, lu_busy_o[i], luBusy(i));
         checkOne("lu_wb_valid", i, lu_wbv_o[i], wbv);
         checkOne("lu_wb_rd", i, lu_wbrd_o[i], wbv ? lu_dst[i] : 5'd0);
      end
   endtask

   task automatic modelAdvance();
      ent_t e;
      logic st;
      for (int i = 0; i < NCFG; i++) begin
         st = expLoadStall(i) || expLongStall(i);
         e  = '0;
         if (lu_active[i] && cyc >= lu_first[i] + lu_len[i])
            lu_active[i] = 1'b0;
         if (id_valid && !st) begin
            e.v   = 1'b1;
            e.rd  = id_rd;
            e.rs1 = id_rs1;
            e.rs2 = id_rs2;
            e.wen = id_wen && id_kind != 2'b10;
            e.ld  = (id_kind == 2'b01);
            if (id_kind == 2'b10) begin
               lu_active[i] = 1'b1;
               lu_first[i]  = cyc + 1;
               lu_len[i]    = (id_lat == 6'd0) ? 1 : int'(id_lat);
               lu_dst[i]    = id_rd;
            end
         end
         issued_log[i][(cyc + 1) % LOGN] = e;
      end
      cyc = cyc + 1;
   endtask

   task automatic finishCycle();
      @(posedge clk);
      modelAdvance();
      @(negedge clk);
   endtask

   task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wen, input logic [1:0] kind,
                       input logic [5:0] lat, input logic br);
      applyStimulus(v, rs1, rs2, rd, wen, kind, lat, br);
      checkOutput();
      finishCycle();
   endtask

   task automatic drain();
      repeat (4) step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 6'd0, 1'b0);
   endtask

   // Reset is dropped between edges so the asynchronous clear is observed on its own
   task automatic doReset();
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 6'd0, 1'b0);
      rst = 1'b0;
      #1;
      for (int i = 0; i < NCFG; i++) begin
         checkOne("rst_stall", i, stall_o[i], 0);
         checkOne("rst_bubble", i, bubble_o[i], 0);
         checkOne("rst_flush", i, flush_o[i], 0);
         checkOne("rst_fwd_a", i, fwd_a_o[i], 0);
         checkOne("rst_fwd_b", i, fwd_b_o[i], 0);
         checkOne("rst_lu_start", i, lu_start_o[i], 0);
         checkOne("rst_lu_busy", i, lu_busy_o[i], 0);
         checkOne("rst_lu_wb_valid", i, lu_wbv_o[i], 0);
         checkOne("rst_lu_wb_rd", i, lu_wbrd_o[i], 0);
         lu_active[i] = 1'b0;
      end
      cyc = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   function automatic logic [1:0] randKind();
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) return 2'b00;
      if (r < 7) return 2'b01;
      if (r == 7) return 2'b10;
      return 2'b11;
   endfunction

   initial begin
      int         stall_cycles;
      int         wb_at;
      int         wb_seen;
      logic [4:0] wb_rd;

      #2;
      doReset();

      // ld x5 ; add x6,x5,x1
      step(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 2'b01, 6'd0, 1'b0);
      applyStimulus(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 2'b00, 6'd0, 1'b0);
      checkOutput();
      checkOne("ldUseStall", 0, stall_o[0], 1);
      checkOne("ldUseBubble", 0, bubble_o[0], 1);
      finishCycle();
      applyStimulus(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 2'b00, 6'd0, 1'b0);
      checkOutput();
      checkOne("ldUseRelease", 0, stall_o[0], 0);
      finishCycle();
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 6'd0, 1'b0);
      checkOutput();
      checkOne("ldUseFwdA", 0, fwd_a_o[0], 2);
      checkOne("ldUseFwdB", 0, fwd_b_o[0], 0);
      finishCycle();
      drain();

      // add x5 ; sub x7,x5,x5 ; or x8,x5,x0
      step(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 2'b00, 6'd0, 1'b0);
      applyStimulus(1'b1, 5'd5, 5'd5, 5'd7, 1'b1, 2'b00, 6'd0, 1'b0);
      checkOutput();
      checkOne("aluNoStall", 0, stall_o[0], 0);
      finishCycle();
      applyStimulus(1'b1, 5'd5, 5'd0, 5'd8, 1'b1, 2'b00, 6'd0, 1'b0);
      checkOutput();
      checkOne("subFwdA", 0, fwd_a_o[0], 1);
      checkOne("subFwdB", 0, fwd_b_o[0], 1);
      finishCycle();
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 6'd0, 1'b0);
      checkOutput();
      checkOne("orFwdA", 0, fwd_a_o[0], 2);
      checkOne("orFwdB", 0, fwd_b_o[0], 0);
      finishCycle();
      drain();

      // ld x3 ; addi x4,x3,1 on the 4-stage, 2-cycle-load configuration
      step(1'b1, 5'd1, 5'd0, 5'd3, 1'b1, 2'b01, 6'd0, 1'b0);
      for (int n = 0; n < 3; n++) begin
         applyStimulus(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 2'b00, 6'd0, 1'b0);
         checkOutput();
         checkOne("lat2Stall", 1, stall_o[1], (n < 2) ? 1 : 0);
         finishCycle();
      end
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 6'd0, 1'b0);
      checkOutput();
      checkOne("lat2FwdA", 1, fwd_a_o[1], 3);
      finishCycle();
      drain();

      // div x9 (latency 10) ; add x10,x9,x2
      step(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 2'b10, 6'd10, 1'b0);
      stall_cycles = 0;
      wb_at = 0;
      wb_rd = 5'd0;
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'b1, 5'd9, 5'd2, 5'd10, 1'b1, 2'b00, 6'd0, 1'b0);
         checkOutput();
         if (i == 0)
            checkOne("luStartPulse", 0, lu_start_o[0], 1);
         if (stall_o[0] !== 1'b1)
            break;
         stall_cycles = stall_cycles + 1;
         if (lu_wbv_o[0] === 1'b1) begin
            wb_at = stall_cycles;
            wb_rd = lu_wbrd_o[0];
         end
         finishCycle();
      end
      checkOne("luStallCycles", 0, stall_cycles, 11);
      checkOne("luWbCycle", 0, wb_at, 11);
      checkOne("luWbRd", 0, wb_rd, 9);
      finishCycle();
      drain();

      // ld x5 then a taken branch reading x5
      step(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 2'b01, 6'd0, 1'b0);
      applyStimulus(1'b1, 5'd5, 5'd6, 5'd0, 1'b0, 2'b11, 6'd0, 1'b1);
      checkOutput();
      checkOne("flushStall", 0, stall_o[0], 1);
      checkOne("flushHeld", 0, flush_o[0], 0);
      finishCycle();
      applyStimulus(1'b1, 5'd5, 5'd6, 5'd0, 1'b0, 2'b11, 6'd0, 1'b1);
      checkOutput();
      checkOne("flushAfter", 0, flush_o[0], 1);
      finishCycle();
      drain();

      // x0 never creates a hazard or a forward
      step(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 2'b00, 6'd0, 1'b0);
      applyStimulus(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 2'b00, 6'd0, 1'b0);
      checkOutput();
      checkOne("x0NoStall", 0, stall_o[0], 0);
      finishCycle();
      step(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 2'b01, 6'd0, 1'b0);
      applyStimulus(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 2'b00, 6'd0, 1'b0);
      checkOutput();
      checkOne("x0LoadNoStall", 0, stall_o[0], 0);
      checkOne("x0NoFwdA", 0, fwd_a_o[0], 0);
      checkOne("x0NoFwdB", 0, fwd_b_o[0], 0);
      finishCycle();
      drain();

      // Abandon a long op with reset while it is busy
      step(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 2'b10, 6'd20, 1'b0);
      step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 6'd0, 1'b0);
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 6'd0, 1'b0);
      checkOutput();
      checkOne("busyBeforeRst", 0, lu_busy_o[0], 1);
      finishCycle();
      doReset();
      wb_seen = 0;
      for (int n = 0; n < 30; n++) begin
         applyStimulus(1'b1, 5'd12, 5'd0, 5'd13, 1'b1, 2'b00, 6'd0, 1'b0);
         checkOutput();
         if (lu_wbv_o[0] !== 1'b0)
            wb_seen = wb_seen + 1;
         finishCycle();
      end
      checkOne("noWbAfterRst", 0, wb_seen, 0);

      // Random traffic over a small register window to provoke dense hazards
      for (int n = 0; n < 600; n++) begin
         step($urandom_range(0, 9) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 1'($urandom), randKind(), 6'($urandom_range(0, 6)),
              $urandom_range(0, 3) == 0);
         if (n == 300)
            doReset();
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard, forwarding and stall controller for the RV64I in-order pipeline.
- Generalises the fixed 5-stage load-use detector and two-level forwarder to N post-ID stages and configurable load latency.
- Adds a scoreboard and handshake for one variable-latency unit (mul/div).
- Sits beside the ID stage; drives PC/IFID write enables, ID/EX bubble, IF flush and EX operand-mux selects.

Parameters:
- RAW, 5: register index width.
- STAGES, 3: post-ID stages tracked (index 0 = EX, 1 = MEM, 2 = WB, ...); legal range STAGES >= LOAD_LAT+2.
- LOAD_LAT, 1: extra stages after MEM entry before load data is forwardable.
- LATW, 6: width of the long-op latency field.
- Derived: FW = $clog2(STAGES).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  valid instruction in ID
- id_rs1  in  RAW  source 1 index
- id_rs2  in  RAW  source 2 index
- id_rd  in  RAW  destination index
- id_wen  in  1  instruction writes id_rd
- id_kind  in  2  00 ALU, 01 load, 10 long-latency, 11 store/branch
- id_lat  in  LATW  long-op latency in cycles (0 treated as 1)
- branch_taken  in  1  ID-stage branch compare result
- stall  out  1  PC_Write = IFID_Write = ~stall
- bubble  out  1  force ID/EX control fields to 0
- if_flush  out  1  replace IFID instruction with NOP
- fwd_a  out  FW  EX operand A select: 0 = regfile, k = stage k pipeline register
- fwd_b  out  FW  EX operand B select, same encoding
- lu_start  out  1  one-cycle start pulse to long unit
- lu_busy  out  1  long unit not IDLE
- lu_wb_valid  out  1  long result writes regfile this cycle (second write port)
- lu_wb_rd  out  RAW  long result destination

Behaviour:
- Reset (rst low, async):
  - All tags invalid; ex_rs1/ex_rs2 = 0; FSM IDLE; counter 0.
  - stall = bubble = if_flush = lu_start = lu_wb_valid = 0; fwd_a = fwd_b = 0; lu_wb_rd = 0.
- Tag pipe:
  - tag[k] = {v, rd, wen, ld} for k = 0..STAGES-1; shifts every clock (tag[k] <= tag[k-1]).
  - tag[0] loads the ID instruction when id_valid & ~stall. It loads invalid when stalled or when no valid instruction is in ID.
  - For long ops, tag[0].wen = 0; the long unit owns that write.
  - ex_rs1/ex_rs2 register id_rs1/id_rs2 under the same condition as tag[0]; they are cleared on bubble.
- match(k, r) = tag[k].v & tag[k].wen & tag[k].rd == r & r != 0. x0 never matches.
- Load-use stall: stall if id_valid and, for any k < LOAD_LAT, match(k, id_rs1|id_rs2) & tag[k].ld. Defaults give 1 stall cycle.
- Forwarding (combinational from ex_rs, k = 1..STAGES-1):
  - fwd_a = the smallest k with match(k, ex_rs1), else 0; the youngest producer wins.
  - fwd_b is computed the same way from ex_rs2, independently. Both operands may forward in the same cycle.
- Long-unit FSM:
  - IDLE: id_kind == 10 & id_valid & ~stall → lu_start = 1; latch rd and count = max(id_lat, 1); go to BUSY.
  - BUSY: count decrements each cycle; on reaching 1, go to DONE.
  - DONE: lu_wb_valid = 1 for exactly one cycle with lu_wb_rd; then IDLE.
- Long-unit stalls, asserted in BUSY or DONE:
  - Structural: id_kind == 10.
  - RAW: id_rs1/id_rs2 == lu rd (nonzero).
  - WAW: id_wen & id_rd == lu rd.
  - A dependent instruction issues the cycle after DONE, so it stalls exactly id_lat+1 cycles after lu_start.
- bubble = stall.
- if_flush = id_valid & branch_taken & ~stall. Stall has priority; the flush occurs in the first unstalled cycle.
- Reset asserted mid-operation: a BUSY long op is abandoned with no lu_wb_valid, and every tag is cleared.

Optional Feature:
- Macro HAZ_PERF_EN.
- When defined:
  - Adds outputs perf_load_stalls[31:0], perf_long_stalls[31:0] and perf_flushes[31:0].
  - Each counts cycles in which the respective stall cause, or if_flush, is asserted.
  - A cycle with both stall causes increments both counters; counters saturate at all-ones and reset to 0.
- When undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- ld x5; add x6,x5,x1 back-to-back → stall = bubble = 1 for 1 cycle; add in EX with fwd_a = 2, fwd_b = 0.
- add x5; sub x7,x5,x5; or x8,x5,x0 → no stall; sub gets fwd_a = fwd_b = 1; or gets fwd_a = 2, fwd_b = 0.
- STAGES = 4, LOAD_LAT = 2: ld x3; addi x4,x3,1 → 2 stall cycles, then fwd_a = 3.
- div x9 with id_lat = 10, then add x10,x9,x2 → lu_start one cycle; 11 stall cycles; lu_wb_valid = 1 with lu_wb_rd = 9 on the 11th; add issues the next cycle.
- Load-use hazard plus branch_taken = 1 in ID → if_flush = 0 while stall = 1; if_flush = 1 on the following cycle.
- Writes to x0 (add x0; use x0), then rst low mid-BUSY → no stall or forward for x0; after reset all outputs 0, lu_busy = 0, no writeback pulse.
